mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the data port (port B) of the dual-port code/data RAM between two requesters:
//   requester 0 = CPU load/store unit, requester 1 = boot loader / debug DMA.
//   Accepts one request at a time, drives the RAM port from registers, and returns
//   read data (or a write acknowledge) with the RAM's one-cycle read latency.
//   Sits between the CPU core, the loader and the RAM instance in the top level.
// PARAMETERS
//   NUM_COL     4                    byte lanes per word
//   COL_WIDTH   8                    bits per lane
//   ADDR_WIDTH  15                   word address width
//   DATA_WIDTH  NUM_COL*COL_WIDTH    word width
// PORTS
//   clk         in   1                 system clock
//   rst         in   1                 asynchronous reset, active-high
//   req_valid   in   2                 request valid, bit i = requester i
//   req_ready   out  2                 request accepted this cycle (one-hot or zero)
//   req_we      in   2*NUM_COL         byte write enables, slice i = requester i
//   req_addr    in   2*ADDR_WIDTH      word address, slice i = requester i
//   req_wdata   in   2*DATA_WIDTH      write data, slice i = requester i
//   resp_valid  out  2                 response pulse, one-hot
//   resp_rdata  out  DATA_WIDTH        read data (old word for writes), valid with resp_valid
//   grant_id    out  1                 requester owning the in-flight transaction
//   mem_en      out  1                 RAM port enable
//   mem_we      out  NUM_COL           RAM byte write enables
//   mem_addr    out  ADDR_WIDTH        RAM address
//   mem_din     out  DATA_WIDTH        RAM write data
//   mem_dout    in   DATA_WIDTH        RAM read data (registered, 1-cycle latency, read-first)
// BEHAVIOUR
//   - Reset: state IDLE; req_ready, resp_valid, mem_en, mem_we, mem_addr, mem_din,
//     resp_rdata, grant_id = 0; last_grant = 1 (requester 0 wins first tie).
//   - FSM IDLE -> ISSUE -> RESP -> IDLE; one transaction per 3 cycles, no pipelining.
//   - IDLE, cycle T: if any req_valid, arbiter picks g; req_ready[g]=1 combinationally
//     (only in IDLE, never during rst); register g into grant_id, slice g into
//     mem_we/mem_addr/mem_din, set mem_en; go ISSUE. No valid: stay IDLE, mem_en=0.
//   - ISSUE, T+1: mem_en=1 with held command; RAM samples at end of T+1. Clear mem_en
//     and mem_we at that edge; go RESP.
//   - RESP, T+2: resp_valid[grant_id]=1 for exactly one cycle, resp_rdata=mem_dout
//     (registered copy held until next response); go IDLE. req_ready=0 in ISSUE/RESP.
//   - Handshake: requester holds valid and payload stable until ready; a requester may
//     assert its next valid during RESP; it is considered in the following IDLE cycle.
//   - Arbitration: only requesters with valid set are candidates; single candidate
//     always wins; tie resolved per CONFIGURATION; last_grant updated on every accept.
//   - Write with all req_we=0 is a plain read. Address used unmodified (word address,
//     no wrap logic; upper bits beyond ADDR_WIDTH do not exist).
//   - Reset mid-transaction: all outputs clear immediately; in-flight transaction dropped,
//     no resp_valid; a write in ISSUE is committed only if its clock edge preceded rst.
// CONFIGURATION
//   MEM_ARB_ROUND_ROBIN_EN defined: tie goes to requester != last_grant (alternates
//     0,1,0,1 under continuous contention).
//   Not defined: fixed priority, requester 0 (CPU) always wins ties; last_grant kept
//     but unused for selection.
// STRUCTURE
//   - constant_defs.v: ARB_IDLE/ARB_ISSUE/ARB_RESP state encodings (2 bits), REQ_CPU=0,
//     REQ_LOADER=1.
//   - Sub-module arb_pick2: combinational 2-way picker (valid[1:0], last_grant,
//     -> grant, any); holds the MEM_ARB_ROUND_ROBIN_EN selection logic.
//   - Top: FSM, command/response registers, payload muxing.
// TESTING
//   - Single read: req0 addr=0x0010 (RAM preloaded 0xDEADBEEF) -> ready0 at T, mem_en at
//     T+1 with addr 0x0010, resp_valid0 at T+2 with rdata 0xDEADBEEF.
//   - Byte write: req1 we=4'b0010 wdata=0x0000AB00 addr=0x0020 (old 0x11223344) ->
//     resp_valid1, rdata 0x11223344; later read returns 0x1122AB44.
//   - Contention: both valid for 4 transactions -> fixed: grant order 0,0,0,0 (req1 starved
//     while req0 valid); with MEM_ARB_ROUND_ROBIN_EN: 0,1,0,1.
//   - Back-to-back: req0 reasserts valid during RESP -> next accept in following IDLE,
//     accepts exactly 3 cycles apart, never two ready pulses in 3 cycles.
//   - Reset in ISSUE: rst high mid-write -> mem_en, resp_valid, req_ready 0 same cycle,
//     no response; after release first accept behaves as post-reset (req0 wins tie).
//   - Idle: no valid for 10 cycles -> mem_en=0, req_ready=0, resp_valid=0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arbState_t;

  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  // Turns a requester index into its one-hot ready/response lane.
  function automatic logic [1:0] grantOneHot(input logic grantIdx);
    return grantIdx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick2.sv
// Two-way requester picker; MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break, else CPU priority.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed.
module arb_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       lastGrant,
  output logic       grant,
  output logic       any
);

  assign any = |valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Single candidate wins outright; on a tie the requester that did not win last time goes.
  always_comb begin
    grant = REQ_CPU;
    if (valid == 2'b11) begin
      grant = ~lastGrant;
    end else if (valid[1]) begin
      grant = REQ_LOADER;
    end
  end
`else
  // Fixed priority: the CPU wins whenever it is asking; the history bit plays no part.
  logic unusedLastGrant;
  assign unusedLastGrant = lastGrant;

  always_comb begin
    grant = REQ_CPU;
    if (!valid[0] && valid[1]) begin
      grant = REQ_LOADER;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares RAM port B between CPU (0) and loader/DMA (1); tie-break set by MEM_ARB_ROUND_ROBIN_EN.
// Latency: accept at T, RAM command at T+1, resp_valid with read data at T+2; one transaction per 3 cycles.
// Backpressure: req_ready pulses only in IDLE; requesters hold valid/payload until they see it.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*NUM_COL-1:0]    req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    grant_id,
  output logic                    mem_en,
  output logic [NUM_COL-1:0]      mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);

  arbState_t             arbState;
  logic                  lastGrant;
  logic                  pickGrant;
  logic                  pickAny;
  logic [1:0]            respValid;
  logic [DATA_WIDTH-1:0] rdataHold;
  logic [NUM_COL-1:0]    pickWe;
  logic [ADDR_WIDTH-1:0] pickAddr;
  logic [DATA_WIDTH-1:0] pickWdata;

  arb_pick2 uPick (
    .valid    (req_valid),
    .lastGrant(lastGrant),
    .grant    (pickGrant),
    .any      (pickAny)
  );

  // Payload of whichever requester the picker chose this cycle.
  always_comb begin
    pickWe    = pickGrant ? req_we[2*NUM_COL-1:NUM_COL]          : req_we[NUM_COL-1:0];
    pickAddr  = pickGrant ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : req_addr[ADDR_WIDTH-1:0];
    pickWdata = pickGrant ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  end

  // Accept is combinational so the requester sees it in the same IDLE cycle; reset masks it at once.
  assign req_ready  = (arbState == ARB_IDLE && !rst && pickAny) ? grantOneHot(pickGrant) : 2'b00;
  assign resp_valid = respValid;

  // RAM data arrives during RESP; pass it straight through then and hold a copy until the next response.
  assign resp_rdata = (arbState == ARB_RESP) ? mem_dout : rdataHold;

  // Transaction sequencer: IDLE latches the command, ISSUE lets the RAM sample it, RESP returns data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arbState  <= ARB_IDLE;
      lastGrant <= REQ_LOADER;
      grant_id  <= REQ_CPU;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
      respValid <= 2'b00;
      rdataHold <= '0;
    end else begin
      case (arbState)
        ARB_IDLE: begin
          respValid <= 2'b00;
          if (pickAny) begin
            grant_id  <= pickGrant;
            lastGrant <= pickGrant;
            mem_en    <= 1'b1;
            mem_we    <= pickWe;
            mem_addr  <= pickAddr;
            mem_din   <= pickWdata;
            arbState  <= ARB_ISSUE;
          end else begin
            mem_en <= 1'b0;
            mem_we <= '0;
          end
        end
        ARB_ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= '0;
          respValid <= grantOneHot(grant_id);
          arbState  <= ARB_RESP;
        end
        ARB_RESP: begin
          respValid <= 2'b00;
          rdataHold <= mem_dout;
          arbState  <= ARB_IDLE;
        end
        default: begin
          mem_en    <= 1'b0;
          mem_we    <= '0;
          respValid <= 2'b00;
          arbState  <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
